// File: rtl/servant_irq_gen_if.sv
// rtl/servant_irq_gen_if.sv - Wishbone register bus bundle for servant_irq_gen
interface servant_irq_gen_if;
   logic [1:0]  wb_adr;
   logic [31:0] wb_dat;
   logic [3:0]  wb_sel;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_stb;
   logic [31:0] wb_rdt;
   logic        wb_ack;

   modport master (
      output wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb,
      input  wb_rdt, wb_ack
   );

   modport slave (
      input  wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb,
      output wb_rdt, wb_ack
   );
endinterface

// File: rtl/servant_irq_gen.sv
// rtl/servant_irq_gen.sv - programmable delayed level interrupt for the servant ext_irq pin
// Define SERVANT_IRQ_GEN_PERIODIC_EN to make CTRL.PERIODIC reload and keep counting after each expiry.
module servant_irq_gen #(
   parameter int DELAY_W    = 32,
   parameter int FIRE_CNT_W = 8
) (
   input  logic              wb_clk,
   input  logic              wb_rst_n,
   servant_irq_gen_if.slave  wb,
   output logic              ext_irq
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_FIRE  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [DELAY_W-1:0]     delay_q;
   logic [DELAY_W-1:0]     count_q, count_d;
   logic [FIRE_CNT_W-1:0]  fire_cnt_q, fire_cnt_d;
   logic                   periodic_q;
   logic                   overrun_q, overrun_d;
   logic                   irq_d;
   logic                   ack_q;
   logic [31:0]            rdt_q;
   logic                   ready_q;

   logic                   access;
   logic                   ctrl_wr;
   logic                   delay_wr;
   logic                   arm_wr;
   logic                   clr_wr;
   logic [31:0]            delay_merged;
   logic [31:0]            status_w;
   logic [31:0]            rd_mux;

   // ready_q holds off the bus for one edge after reset release so the first
   // ack cannot land on the edge that also sees the deassertion.
   assign access   = wb.wb_cyc & wb.wb_stb & ~ack_q & ready_q;
   assign ctrl_wr  = access & wb.wb_we & (wb.wb_adr == 2'd0) & wb.wb_sel[0];
   assign delay_wr = access & wb.wb_we & (wb.wb_adr == 2'd1);
   assign clr_wr   = ctrl_wr & wb.wb_dat[1];
   assign arm_wr   = ctrl_wr & wb.wb_dat[0] & ~wb.wb_dat[1];

   always_comb begin
      delay_merged = 32'(delay_q);
      for (int b = 0; b < 4; b++) begin
         if (wb.wb_sel[b]) begin
            delay_merged[8*b +: 8] = wb.wb_dat[8*b +: 8];
         end
      end
   end

   always_comb begin
      status_w                  = '0;
      status_w[0]               = ext_irq;
      status_w[1]               = (state_q == S_COUNT);
      status_w[2]               = overrun_q;
      status_w[8 +: FIRE_CNT_W] = fire_cnt_q;
   end

   always_comb begin
      rd_mux = '0;
      case (wb.wb_adr)
         2'd0:    rd_mux = {29'b0, periodic_q, 2'b0};
         2'd1:    rd_mux = 32'(delay_q);
         2'd2:    rd_mux = 32'(count_q);
         2'd3:    rd_mux = status_w;
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      fire_cnt_d = fire_cnt_q;
      overrun_d  = overrun_q;
      irq_d      = ext_irq;

      case (state_q)
         S_COUNT: begin
            if (count_q != '0) begin
               count_d = count_q - DELAY_W'(1);
            end else begin
               state_d    = S_FIRE;
               irq_d      = 1'b1;
               fire_cnt_d = fire_cnt_q + FIRE_CNT_W'(1);
`ifdef SERVANT_IRQ_GEN_PERIODIC_EN
               if (periodic_q) begin
                  count_d = delay_q;
               end
`endif
            end
         end
         S_FIRE: begin
`ifdef SERVANT_IRQ_GEN_PERIODIC_EN
            // Periodic mode keeps the counter alive while the interrupt is
            // pending; an expiry here means firmware missed one.
            if (periodic_q) begin
               if (count_q != '0) begin
                  count_d = count_q - DELAY_W'(1);
               end else begin
                  count_d    = delay_q;
                  overrun_d  = 1'b1;
                  fire_cnt_d = fire_cnt_q + FIRE_CNT_W'(1);
               end
            end
`endif
         end
         default: begin
         end
      endcase

      if (clr_wr) begin
         irq_d      = 1'b0;
         overrun_d  = 1'b0;
         fire_cnt_d = fire_cnt_q;
`ifdef SERVANT_IRQ_GEN_PERIODIC_EN
         if (wb.wb_dat[2] && (state_q != S_IDLE)) begin
            state_d = S_COUNT;
            count_d = (count_q != '0) ? count_q - DELAY_W'(1) : count_q;
         end else begin
            state_d = S_IDLE;
            count_d = count_q;
         end
`else
         state_d = S_IDLE;
         count_d = count_q;
`endif
      end else if (arm_wr) begin
         state_d    = S_COUNT;
         count_d    = delay_q;
         irq_d      = 1'b0;
         fire_cnt_d = fire_cnt_q;
         overrun_d  = overrun_q;
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         delay_q    <= '0;
         fire_cnt_q <= '0;
         periodic_q <= 1'b0;
         overrun_q  <= 1'b0;
         ext_irq    <= 1'b0;
         ack_q      <= 1'b0;
         rdt_q      <= '0;
         ready_q    <= 1'b0;
      end else begin
         ready_q    <= 1'b1;
         state_q    <= state_d;
         count_q    <= count_d;
         fire_cnt_q <= fire_cnt_d;
         overrun_q  <= overrun_d;
         ext_irq    <= irq_d;
         ack_q      <= access;
         rdt_q      <= access ? rd_mux : 32'd0;
         if (ctrl_wr) begin
            periodic_q <= wb.wb_dat[2];
         end
         if (delay_wr) begin
            delay_q <= delay_merged[DELAY_W-1:0];
         end
      end
   end

   assign wb.wb_ack = ack_q;
   assign wb.wb_rdt = rdt_q;

endmodule
